// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/fetch-control stage: FSM state encoding,
// HaltCause codes and the default halt instruction encoding.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_HALT_WORD = 2'd1;
    localparam logic [1:0] CAUSE_RANGE     = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd3;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: branch and jump target arithmetic
// plus the JumpReg > Jump > taken-branch > sequential priority mux.
// Purely combinational; all additions wrap modulo 2^ADDRESS_WIDTH.
module pc_next_sel #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4,
    input  logic                     branch,
    input  logic                     zero,
    input  logic                     jump,
    input  logic                     jump_reg,
    input  logic [31:0]              sign_imm,
    input  logic [25:0]              jump_target,
    input  logic [ADDRESS_WIDTH-1:0] reg_target,
    output logic [ADDRESS_WIDTH-1:0] next_pc
);

    logic signed [ADDRESS_WIDTH-1:0] imm_ext;
    logic        [ADDRESS_WIDTH-1:0] branch_target;
    logic        [ADDRESS_WIDTH-1:0] jump_addr;

    // Branch offset is in words; sign-extend, then scale to bytes.
    assign imm_ext       = ADDRESS_WIDTH'($signed(sign_imm));
    assign branch_target = pc_plus4 + ADDRESS_WIDTH'(imm_ext <<< 2);
    assign jump_addr     = {pc_plus4[ADDRESS_WIDTH-1:28], jump_target, 2'b00};

    // Priority mux: register jump, then absolute jump, then taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = reg_target;
        end else if (jump) begin
            next_pc = jump_addr;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for the single-cycle MIPS core.
// Holds the PC, sequences BOOT -> RUN -> HALT, and halts on a halt word,
// an out-of-range fetch, or (with PC_ALIGN_CHECK_EN defined) a misaligned
// next PC. Without PC_ALIGN_CHECK_EN the next PC's low two bits are cleared.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter int                       MEM_DEPTH     = 100,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [INSTR_WIDTH-1:0]   HALT_WORD     = INSTR_WIDTH'(DEFAULT_HALT_WORD)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Stall,
    input  logic                     Branch,
    input  logic                     Zero,
    input  logic                     Jump,
    input  logic                     JumpReg,
    input  logic [31:0]              SignImm,
    input  logic [25:0]              JumpTarget,
    input  logic [ADDRESS_WIDTH-1:0] RegTarget,
    input  logic [INSTR_WIDTH-1:0]   Instr,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4,
    output logic                     InstrValid,
    output logic                     Halted,
    output logic [1:0]               HaltCause
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_LIMIT = ADDRESS_WIDTH'(MEM_DEPTH * 4);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]               cause_q, cause_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] sel_pc;
    logic [ADDRESS_WIDTH-1:0] cand_pc;
    logic                     is_halt_word;
    logic                     misaligned;
    logic                     out_of_range;
    logic                     instr_valid;

    assign pc_plus4     = pc_q + ADDRESS_WIDTH'(4);
    assign is_halt_word = (Instr == HALT_WORD);

    pc_next_sel #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_next_sel (
        .pc_plus4   (pc_plus4),
        .branch     (Branch),
        .zero       (Zero),
        .jump       (Jump),
        .jump_reg   (JumpReg),
        .sign_imm   (SignImm),
        .jump_target(JumpTarget),
        .reg_target (RegTarget),
        .next_pc    (sel_pc)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign cand_pc    = sel_pc;
    assign misaligned = |sel_pc[1:0];
`else
    assign cand_pc    = sel_pc & ~ADDRESS_WIDTH'(3);
    assign misaligned = 1'b0;
`endif

    // Unsigned compare: a wrapped (negative-looking) target is also out of range.
    assign out_of_range = (cand_pc >= PC_LIMIT);

    // State, PC and halt-cause registers; reset returns to BOOT at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state, next-PC and halt checks; Stall freezes everything but InstrValid.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        instr_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (!Stall) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                instr_valid = !is_halt_word;
                if (!Stall) begin
                    if (is_halt_word) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_HALT_WORD;
                    end else if (misaligned) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_MISALIGN;
                    end else if (out_of_range) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_RANGE;
                    end else begin
                        pc_d = cand_pc;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4;
    assign InstrValid = instr_valid;
    assign Halted     = (state_q == ST_HALT);
    assign HaltCause  = cause_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized control
// streams, all compared against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    localparam int unsigned DEPTH = 100;
    localparam logic [31:0] HW    = 32'hFFFF_FFFF;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Stall = 1'b0, Branch = 1'b0, Zero = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
    logic [31:0] SignImm = '0;
    logic [25:0] JumpTarget = '0;
    logic [31:0] RegTarget = '0;
    logic [31:0] Instr = '0;
    logic [31:0] PC, PCPlus4;
    logic        InstrValid, Halted;
    logic [1:0]  HaltCause;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 = booting, 1 = running, 2 = halted.
    logic [31:0] m_pc;
    int          m_mode;
    int          m_cause;

    pc_fetch_unit dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .JumpReg(JumpReg), .SignImm(SignImm), .JumpTarget(JumpTarget),
        .RegTarget(RegTarget), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .InstrValid(InstrValid), .Halted(Halted), .HaltCause(HaltCause)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_mode  = 0;
        m_cause = 0;
    endtask

    // One clock of the fetch rules, using the inputs present at the edge.
    task automatic model_step();
        logic [31:0] seq, tgt;
        if (m_mode == 0) begin
            if (!Stall) m_mode = 1;
        end else if (m_mode == 1 && !Stall) begin
            seq = m_pc + 32'd4;
            if (JumpReg)              tgt = RegTarget;
            else if (Jump)            tgt = (seq & 32'hF000_0000) | ({6'd0, JumpTarget} * 4);
            else if (Branch && Zero)  tgt = seq + SignImm * 4;
            else                      tgt = seq;
            if (!ALIGN_EN) tgt = tgt - (tgt % 4);
            if (Instr == HW) begin
                m_mode = 2; m_cause = 1;
            end else if (ALIGN_EN && (tgt % 4) != 0) begin
                m_mode = 2; m_cause = 3;
            end else if (tgt >= DEPTH * 4) begin
                m_mode = 2; m_cause = 2;
            end else begin
                m_pc = tgt;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".pc"},  PC, m_pc);
        check_eq({tag, ".pc4"}, PCPlus4, m_pc + 32'd4);
        check_eq({tag, ".iv"},  InstrValid, (m_mode == 1) && (Instr != HW));
        check_eq({tag, ".hlt"}, Halted, m_mode == 2);
        check_eq({tag, ".hc"},  HaltCause, m_cause);
    endtask

    // Called just after a rising edge: check at the falling edge, then clock.
    task automatic cycle(input string tag);
        @(negedge CLK);
        check_outputs(tag);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    // Asynchronous reset, checked before any clock edge, held across one edge.
    task automatic do_reset();
        RST = 1'b0;
        #1;
        model_reset();
        check_eq("rst.async_pc", PC, 32'd0);
        check_outputs("rst");
        @(posedge CLK);
        #1;
        check_outputs("rst_hold");
        RST = 1'b1;
    endtask

    task automatic clear_ctl();
        Stall = 0; Branch = 0; Zero = 0; Jump = 0; JumpReg = 0;
        SignImm = '0; JumpTarget = '0; RegTarget = '0; Instr = '0;
    endtask

    task automatic jr_to(input logic [31:0] a);
        clear_ctl();
        JumpReg = 1; RegTarget = a;
        cycle("jr");
        clear_ctl();
    endtask

    initial begin
        #1;
        clear_ctl();
        // Reset release and NOP stream.
        do_reset();
        check_eq("boot.iv", InstrValid, 1'b0);
        cycle("boot");
        check_eq("run0.pc", PC, 32'd0);
        check_eq("run0.iv", InstrValid, 1'b1);
        cycle("seq"); check_eq("seq.pc4", PC, 32'd4);
        cycle("seq"); check_eq("seq.pc8", PC, 32'd8);
        cycle("seq"); check_eq("seq.pc12", PC, 32'd12);

        // Branch taken / not taken from 0x10.
        jr_to(32'h10); check_eq("jr.pc10", PC, 32'h10);
        Branch = 1; Zero = 1; SignImm = 32'hFFFF_FFFE;
        cycle("br_t"); check_eq("br_taken", PC, 32'h0C);
        jr_to(32'h10);
        Branch = 1; Zero = 0; SignImm = 32'hFFFF_FFFE;
        cycle("br_nt"); check_eq("br_not_taken", PC, 32'h14);

        // JumpReg beats Jump; then a plain jump.
        jr_to(32'h20);
        Jump = 1; JumpTarget = 26'h30; JumpReg = 1; RegTarget = 32'h40;
        cycle("jr_j"); check_eq("jr_priority", PC, 32'h40);
        clear_ctl(); Jump = 1; JumpTarget = 26'h30;
        cycle("j"); check_eq("jump", PC, 32'hC0);
        clear_ctl();

        // Halt word under stall, then release.
        do_reset();
        cycle("boot"); cycle("seq"); cycle("seq");
        check_eq("hw.pc8", PC, 32'h08);
        Instr = HW; Stall = 1;
        cycle("hw_stall");
        check_eq("hw_stall.pc", PC, 32'h08);
        check_eq("hw_stall.hlt", Halted, 1'b0);
        Stall = 0;
        cycle("hw");
        check_eq("hw.hlt", Halted, 1'b1);
        check_eq("hw.cause", HaltCause, 2'd1);
        for (int i = 0; i < 5; i++) begin
            Instr = $urandom; Stall = $urandom_range(0, 1); JumpReg = 1; RegTarget = 32'h4;
            cycle("hw_frozen");
            check_eq("hw_frozen.pc", PC, 32'h08);
        end
        clear_ctl();

        // Out-of-range sequential fetch at the top of memory.
        do_reset();
        cycle("boot");
        jr_to(32'h18C); check_eq("top.pc", PC, 32'h18C);
        cycle("range");
        check_eq("range.pc", PC, 32'h18C);
        check_eq("range.cause", HaltCause, 2'd2);

        // Misaligned register jump, then reset mid-operation.
        do_reset();
        cycle("boot");
        jr_to(32'h42);
        if (ALIGN_EN) begin
            check_eq("mis.pc", PC, 32'h0);
            check_eq("mis.cause", HaltCause, 2'd3);
        end else begin
            check_eq("mis.pc", PC, 32'h40);
            cycle("mis_run");
            check_eq("mis_run.pc", PC, 32'h44);
        end
        do_reset();
        check_eq("midrst.pc", PC, 32'h0);
        check_eq("midrst.hlt", Halted, 1'b0);

        // Randomized control streams.
        for (int run = 0; run < 20; run++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                Stall      = ($urandom_range(0, 7) == 0);
                Branch     = ($urandom_range(0, 3) == 0);
                Zero       = $urandom_range(0, 1);
                Jump       = ($urandom_range(0, 7) == 0);
                JumpReg    = ($urandom_range(0, 7) == 0);
                SignImm    = 32'($signed($urandom_range(0, 16)) - 8);
                JumpTarget = 26'($urandom_range(0, 110));
                RegTarget  = 32'($urandom_range(0, 440));
                Instr      = ($urandom_range(0, 29) == 0) ? HW : 32'($urandom_range(0, 32'h7FFF_FFFF));
                cycle("rand");
                if ($urandom_range(0, 49) == 0) do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-control stage directly upstream of the instruction memory in the single-cycle MIPS core. Holds the architectural PC, drives it as the instruction-memory word address, and computes the next PC from sequential, branch, jump and jump-register sources. A small control FSM sequences boot, run, stall and a sticky halt triggered by a halt word or an out-of-range fetch.

## Interface
- ADDRESS_WIDTH, 32, PC and target width.
- INSTR_WIDTH, 32, instruction word width.
- MEM_DEPTH, 100, instruction memory depth in words; legal fetch range is 0 to MEM_DEPTH*4-4.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- CLK  in  1  core clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- Stall  in  1  freezes PC and FSM for the cycle.
- Branch  in  1  conditional branch decoded.
- Zero  in  1  ALU zero flag; branch taken when Branch & Zero.
- Jump  in  1  J/JAL decoded.
- JumpReg  in  1  JR decoded.
- SignImm  in  32  sign-extended branch offset, in words.
- JumpTarget  in  26  J-format index field.
- RegTarget  in  ADDRESS_WIDTH  rs value for JR.
- Instr  in  INSTR_WIDTH  word returned by instruction memory for current PC.
- PC  out  ADDRESS_WIDTH  registered PC; feeds instruction-memory address.
- PCPlus4  out  ADDRESS_WIDTH  PC+4, for JAL link and branch base.
- InstrValid  out  1  Instr is architecturally executable this cycle.
- Halted  out  1  sticky halt flag.
- HaltCause  out  2  0 none, 1 halt word, 2 out of range, 3 misaligned target.

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on reset; PC=RESET_PC, InstrValid=0; goes to RUN on the first clock edge after RST deasserts, PC unchanged.
- RUN: InstrValid=1 unless Instr==HALT_WORD. Next-PC priority: JumpReg -> RegTarget; else Jump -> {PCPlus4[31:28], JumpTarget, 2'b00}; else Branch&Zero -> PCPlus4 + (SignImm<<2); else PCPlus4. All adds are modulo 2^ADDRESS_WIDTH.
- Halt word in RUN: InstrValid=0, PC held, next state HALT, HaltCause=1.
- Out of range: selected next PC >= MEM_DEPTH*4 (unsigned, including wrap past 2^32) -> PC held, HALT, HaltCause=2.
- HALT: terminal until reset; PC held, InstrValid=0, Halted=1, control inputs ignored.
- Stall=1: PC, state and HaltCause held; halt-word and range checks suppressed that cycle; InstrValid still reflects Instr.
- Halt-word check has priority over range check in the same cycle.

## Timing
- Reset values: PC=RESET_PC, PCPlus4=RESET_PC+4, InstrValid=0, Halted=0, HaltCause=0, state BOOT.
- Reset asserted mid-operation returns to BOOT immediately, asynchronously, from any state.
- Control inputs are sampled at the rising edge; a redirect appears on PC one cycle later. Single-cycle core: one instruction per clock, zero bubbles on taken branch or jump.
- PCPlus4, InstrValid and Halted are combinational from PC, state and Instr; no input-to-PC combinational path.

## Configuration
- PC_ALIGN_CHECK_EN defined: a selected next PC with bits [1:0] != 0 (reachable only via JR) leaves PC unchanged, enters HALT, HaltCause=3. This check ranks below the halt-word check and above the range check.
- Not defined: low two bits of the next PC are forced to 0, and HaltCause never reads 3.

## Structure
- Package pc_fetch_pkg holds the FSM state encoding, HaltCause code constants and the default HALT_WORD.
- One sub-module, pc_next_sel: combinational next-PC priority mux plus branch and jump target arithmetic. The top level keeps the FSM, PC register and checks.

## Test plan
- Reset release, NOP stream with Instr=0 -> PC 0 for BOOT and first RUN cycle, then 4, 8, 12; InstrValid 0 then 1.
- PC=0x10, Branch=1, Zero=1, SignImm=-2 -> next PC=0x0C; Zero=0 -> 0x14.
- PC=0x20, Jump=1, JumpTarget=0x30, JumpReg=1, RegTarget=0x40 simultaneously -> next PC=0x40, JumpReg wins.
- Instr=HALT_WORD at PC=0x08 with Stall=1 -> PC stays 0x08 and state stays RUN; drop Stall -> HALT, Halted=1, HaltCause=1, PC frozen at 0x08 through 5 further clocks.
- PC=0x18C with MEM_DEPTH=100 and sequential flow -> next PC 0x190 rejected: PC stays 0x18C, HaltCause=2.
- JR to 0x42: with PC_ALIGN_CHECK_EN -> HALT, HaltCause=3; without it -> PC=0x40, run continues. Assert RST mid-run in both builds -> PC=0 immediately, before the next clock edge.
